// File: rtl/cbrt_pkg.sv
// Shared constants and state encoding for the sequential signed cube-root extractor.
package cbrt_pkg;

    localparam int XW = 12;            // signed operand width
    localparam int RW = 4;             // signed root width
    localparam int MW = 4;             // magnitude search width and iteration count

    localparam int ROOT_MAX = 7;
    localparam int ROOT_MIN = -8;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        DONE
    } state_t;

endpackage

// File: rtl/cube_u.sv
// Combinational unsigned cube of an MW-bit magnitude; 15^3 = 3375 fits in XW bits.
module cube_u
    import cbrt_pkg::*;
(
    input  logic [MW-1:0] a,
    output logic [XW-1:0] y
);

    logic [XW-1:0] a_w;

    assign a_w = XW'(a);
    assign y   = a_w * a_w * a_w;

endmodule

// File: rtl/cube_root_seq.sv
// Sequential signed cube root: restoring bit-serial search over |x|, one trial per clock.
// Optional remainder output enabled by defining CBRT_REMAINDER_EN.
module cube_root_seq
    import cbrt_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic        [XW-1:0] x,
    output logic                 busy,
    output logic                 done,
    output logic signed [RW-1:0] root,
    output logic                 ovf,
    output logic                 exact
`ifdef CBRT_REMAINDER_EN
    ,
    output logic signed [XW-1:0] rem
`endif
);

    localparam int            IW      = $clog2(MW);
    localparam logic [MW-1:0] POS_LIM = MW'(ROOT_MAX);
    localparam logic [MW-1:0] NEG_LIM = MW'(-ROOT_MIN);

    state_t        state, state_nxt;
    logic          sign;
    logic [XW-1:0] mag;
    logic [MW-1:0] r;
    logic [XW-1:0] r_cube;       // cube of r, kept so the final checks need no second multiplier
    logic [IW-1:0] idx;

    logic [MW-1:0] t;
    logic [XW-1:0] t_cube;
    logic          accept;
    logic [MW-1:0] r_fin;
    logic [XW-1:0] cube_fin;

    logic signed [RW-1:0] root_fin;
    logic                 ovf_fin;
    logic                 exact_fin;

    assign t        = r | (MW'(1) << idx);
    assign accept   = (t_cube <= mag);
    assign r_fin    = accept ? t : r;
    assign cube_fin = accept ? t_cube : r_cube;

    cube_u u_cube (
        .a (t),
        .y (t_cube)
    );

    // NOTE: every signal driven from always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        root_fin = '0;
        ovf_fin  = 1'b0;
        if (!sign) begin
            if (r_fin > POS_LIM) begin
                root_fin = RW'(ROOT_MAX);
                ovf_fin  = 1'b1;
            end else begin
                root_fin = RW'(r_fin);
            end
        end else begin
            if (r_fin > NEG_LIM) begin
                root_fin = RW'(ROOT_MIN);
                ovf_fin  = 1'b1;
            end else begin
                root_fin = RW'(-r_fin);
            end
        end
        exact_fin = !ovf_fin && (cube_fin == mag);
    end

`ifdef CBRT_REMAINDER_EN
    logic [XW-1:0] x_val;
    logic [XW-1:0] root_cube;
    logic [XW-1:0] rem_fin;

    // Saturated roots have fixed cubes; otherwise reuse the tracked magnitude cube.
    always_comb begin
        x_val = sign ? (~mag + 1'b1) : mag;
        if (ovf_fin)
            root_cube = sign ? XW'(ROOT_MIN * ROOT_MIN * ROOT_MIN) : XW'(ROOT_MAX * ROOT_MAX * ROOT_MAX);
        else
            root_cube = sign ? (~cube_fin + 1'b1) : cube_fin;
        rem_fin = x_val - root_cube;
    end
`endif

    // NOTE: sequential state is written with non-blocking assignments only, so all registers update together.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ITER;
            ITER:    if (idx == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sign   <= 1'b0;
            mag    <= '0;
            r      <= '0;
            r_cube <= '0;
            idx    <= '0;
            root   <= '0;
            ovf    <= 1'b0;
            exact  <= 1'b0;
`ifdef CBRT_REMAINDER_EN
            rem    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sign   <= x[XW-1];
                        mag    <= x[XW-1] ? (~x + 1'b1) : x;
                        r      <= '0;
                        r_cube <= '0;
                        idx    <= IW'(MW - 1);
                    end
                end
                ITER: begin
                    r      <= r_fin;
                    r_cube <= cube_fin;
                    idx    <= idx - 1'b1;
                    if (idx == '0) begin
                        root  <= root_fin;
                        ovf   <= ovf_fin;
                        exact <= exact_fin;
`ifdef CBRT_REMAINDER_EN
                        rem   <= rem_fin;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cube_root_seq.sv
// Self-checking bench for cube_root_seq: cycle-level behavioural model plus directed literal checks.
// Define CBRT_REMAINDER_EN to also exercise the rem output.
module tb_cube_root_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic        [11:0] x;
    logic               busy;
    logic               done;
    logic signed [3:0]  root;
    logic               ovf;
    logic               exact;
`ifdef CBRT_REMAINDER_EN
    logic signed [11:0] rem;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    cube_root_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .busy  (busy),
        .done  (done),
        .root  (root),
        .ovf   (ovf),
        .exact (exact)
`ifdef CBRT_REMAINDER_EN
        ,
        .rem   (rem)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    // Reference: floor cube root of |x| by plain integer search, then saturate.
    function automatic void model(input int xv, output int r_o, output int ovf_o,
                                  output int ex_o, output int rem_o);
        int m;
        int r;
        m = (xv < 0) ? -xv : xv;
        r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= m) r++;
        ovf_o = 0;
        if (xv >= 0) begin
            if (r > 7) begin r_o = 7; ovf_o = 1; end
            else r_o = r;
        end else begin
            if (r > 8) begin r_o = -8; ovf_o = 1; end
            else r_o = -r;
        end
        ex_o  = (!ovf_o && r * r * r == m) ? 1 : 0;
        rem_o = xv - r_o * r_o * r_o;
    endfunction

    // Model timeline: since = cycles since acceptance (0 = idle, 5 = result cycle).
    int since = 0;
    bit armed = 0;
    int e_root = 0, e_ovf = 0, e_exact = 0, e_rem = 0;
    int p_root, p_ovf, p_exact, p_rem;

    always @(posedge clk) begin
        if (rst) begin
            armed   = 1;
            since   = 0;
            e_root  = 0;
            e_ovf   = 0;
            e_exact = 0;
            e_rem   = 0;
        end else if (since == 0) begin
            if (start === 1'b1) begin
                model(int'($signed(x)), p_root, p_ovf, p_exact, p_rem);
                since = 1;
            end
        end else if (since == 5) begin
            since = 0;
        end else begin
            since++;
            if (since == 5) begin
                e_root  = p_root;
                e_ovf   = p_ovf;
                e_exact = p_exact;
                e_rem   = p_rem;
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] got, exp;
        logic [11:0] got_rem;
        if (armed) begin
`ifdef CBRT_REMAINDER_EN
            got_rem = rem;
`else
            got_rem = 12'd0;
`endif
            got = {12'd0, busy, done, ovf, exact, root, got_rem};
            exp = {12'd0, since != 0, since == 5, e_ovf[0], e_exact[0], e_root[3:0],
`ifdef CBRT_REMAINDER_EN
                   e_rem[11:0]};
`else
                   12'd0};
`endif
            check("cycle_model", got, exp);
        end
    end

    task automatic wait_done(input string nm, output int cycles);
        cycles = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                cycles = n;
                return;
            end
        end
        check({nm, "_timeout"}, 0, 1);
    endtask

    task automatic check_result(input string nm, input int er, input int eo, input int ee, input int erem);
        check({nm, "_root"}, root, er);
        check({nm, "_ovf"}, {31'd0, ovf}, eo);
        check({nm, "_exact"}, {31'd0, exact}, ee);
`ifdef CBRT_REMAINDER_EN
        check({nm, "_rem"}, rem, erem);
`endif
    endtask

    task automatic run(input string nm, input logic [11:0] xv, input int er, input int eo,
                       input int ee, input int erem);
        int c;
        @(posedge clk); #2;
        start = 1'b1;
        x     = xv;
        @(posedge clk); #2;
        start = 1'b0;
        x     = ~xv;
        wait_done(nm, c);
        check({nm, "_latency"}, c, 5);
        check_result(nm, er, eo, ee, erem);
    endtask

    initial begin
        int c1, c2;
        rst   = 1'b1;
        start = 1'b0;
        x     = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check_result("reset", 0, 0, 0, 0);

        // Handshake timing for x=27.
        @(posedge clk); #2;
        start = 1'b1;
        x     = 12'd27;
        @(posedge clk); #2;
        start = 1'b0;
        x     = 12'hABC;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            check($sformatf("x27_busy_c%0d", k), {31'd0, busy}, (k <= 5) ? 1 : 0);
            check($sformatf("x27_done_c%0d", k), {31'd0, done}, (k == 5) ? 1 : 0);
            if (k == 5) check_result("x27", 3, 0, 1, 0);
        end

        run("xm343",  -12'sd343,  -7, 0, 1, 0);
        run("xm512",  -12'sd512,  -8, 0, 1, 0);
        run("x100",    12'sd100,   4, 0, 0, 36);
        run("xm100",  -12'sd100,  -4, 0, 0, -36);
        run("x2047",   12'sd2047,  7, 1, 0, 1704);
        run("xm2048",  12'h800,   -8, 1, 0, -1536);
        run("xm600",  -12'sd600,  -8, 0, 0, -88);

        // start held high: second request accepted only after DONE.
        @(posedge clk); #2;
        start = 1'b1;
        x     = 12'd8;
        @(posedge clk); #2;
        x     = 12'd64;
        wait_done("hold1", c1);
        check("hold1_latency", c1, 5);
        check_result("hold1", 2, 0, 1, 0);
        wait_done("hold2", c2);
        check("hold2_gap", c2, 6);
        check_result("hold2", 4, 0, 1, 0);
        @(posedge clk); #2;
        start = 1'b0;

        run("x0", 12'd0, 0, 0, 1, 0);
        run("x100b", 12'sd100, 4, 0, 0, 36);

        // Reset in the second ITER cycle aborts with outputs cleared.
        @(posedge clk); #2;
        start = 1'b1;
        x     = 12'd1000;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_done", {31'd0, done}, 0);
        check_result("abort", 0, 0, 0, 0);
        c1 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done === 1'b1) c1++;
        end
        check("abort_no_done", c1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
